// File: rtl/aes_ecb_block_sequencer.sv
// ECB sequencer: packs 16 plaintext RAM bytes per block into aes_pt, runs the AES core,
// then writes the 16 ciphertext bytes out; NUM_BLOCKS blocks per start, err on core timeout.
module aes_ecb_block_sequencer #(
   parameter int NUM_BLOCKS  = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [2:0]   blk_idx,
   output logic [6:0]   pt_rd_addr,
   input  logic [7:0]   pt_rd_data,
   output logic [127:0] aes_pt,
   output logic         aes_start,
   input  logic         aes_done,
   input  logic [127:0] aes_ct,
   output logic         ct_wr_en,
   output logic [6:0]   ct_wr_addr,
   output logic [7:0]   ct_wr_data
);
   localparam int            TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [2:0]    BLK_LAST = 3'(NUM_BLOCKS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_STORE, S_NEXT, S_FIN
   } state_t;

   state_t        state, state_nxt;
   logic [4:0]    cnt;
   logic [4:0]    cap_idx;
   logic [TW-1:0] tmo;
   logic [127:0]  pt_q;
   logic [127:0]  ct_q;

   // RAM read data lags the address by one cycle, so LOAD step k captures byte k-1
   assign cap_idx = cnt - 5'd1;
   assign aes_pt  = pt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  if (cnt == 5'd16) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (aes_done)             state_nxt = S_STORE;
            else if (tmo == TMO_LAST) state_nxt = S_FIN;
         end
         S_STORE: if (cnt == 5'd15) state_nxt = S_NEXT;
         S_NEXT:  state_nxt = (blk_idx == BLK_LAST) ? S_FIN : S_LOAD;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != S_IDLE);
      done       = (state == S_FIN);
      aes_start  = (state == S_ISSUE);
      ct_wr_en   = (state == S_STORE);
      pt_rd_addr = {blk_idx, cnt[3:0]};
      ct_wr_addr = {blk_idx, cnt[3:0]};
      ct_wr_data = ct_q[{cnt[3:0], 3'b000} +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         tmo     <= '0;
         pt_q    <= '0;
         ct_q    <= '0;
         blk_idx <= '0;
         err     <= 1'b0;
      end else begin
         if ((state == S_LOAD || state == S_STORE) && state_nxt == state) cnt <= cnt + 5'd1;
         else                                                              cnt <= '0;

         if (state == S_LOAD && cnt != 5'd0)
            pt_q[{cap_idx[3:0], 3'b000} +: 8] <= pt_rd_data;

         if (state == S_WAIT) tmo <= tmo + TW'(1);
         else                 tmo <= '0;

         if (state == S_WAIT && aes_done) ct_q <= aes_ct;

         case (state)
            S_IDLE: if (start) begin
               blk_idx <= '0;
               err     <= 1'b0;
            end
            S_WAIT: if (!aes_done && tmo == TMO_LAST) err <= 1'b1;
            S_NEXT: if (blk_idx != BLK_LAST) blk_idx <= blk_idx + 3'd1;
            default: ;
         endcase
      end
   end
endmodule
